// File: rtl/cpu_pkg.sv
// Shared CPU definitions: link state encoding, byte-enable width and the
// write-back data select encoding used by the MEM/WB stage.
package cpu_pkg;

   typedef enum logic {
      UNLINKED = 1'b0,
      LINKED   = 1'b1
   } link_state_t;

   localparam int BYTE_EN_W = 4;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_SC  = 2'd2
   } wb_sel_t;

   // Memory data outranks the SC flag, which outranks the ALU result.
   function automatic wb_sel_t wb_select(input logic sel_mem, input logic atomic);
      if (sel_mem)
         return WB_MEM;
      else if (atomic)
         return WB_SC;
      return WB_ALU;
   endfunction

endpackage

// File: rtl/llsc_link.sv
// Load-link / store-conditional reservation tracker.
// Build with LINK_SNOOP_EN defined to drop the reservation on a matching plain store.
module llsc_link
   import cpu_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic            kill,
   input  logic            load_link_,
   input  logic            check_link,
`ifdef LINK_SNOOP_EN
   input  logic            store_,
`endif
   input  logic [BITS-1:0] addr,
   output logic            link_valid,
   output logic [BITS-1:0] link_addr,
   output logic            hit,
   output logic            sc_ok
);

   link_state_t      state_reg, state_next;
   logic [BITS-1:0]  link_addr_reg, link_addr_next;

   assign link_valid = (state_reg == LINKED);
   assign link_addr  = link_addr_reg;
   assign hit        = link_valid && (addr == link_addr_reg);
   assign sc_ok      = hit;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_reg     <= UNLINKED;
         link_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         link_addr_reg <= link_addr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      link_addr_next = link_addr_reg;
      if (!kill) begin
         if (!load_link_) begin
            link_addr_next = addr;
            state_next     = LINKED;
         end else if (check_link) begin
            state_next = UNLINKED;
         end
`ifdef LINK_SNOOP_EN
         else if (!store_ && hit) begin
            state_next = UNLINKED;
         end
`endif
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: data memory port, LL/SC link and
// write-back capture. Optional LINK_SNOOP_EN lets plain stores break a reservation.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int REG_WORDS = 32
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         sel_mem_s4,
   input  logic                         atomic_s4,
   input  logic                         check_link_s4,
   input  logic                         load_link_s4_,
   input  logic                         mem_rw_s4,
   input  logic                         rw_s4,
   input  logic [$clog2(REG_WORDS)-1:0] waddr_s4,
   input  logic [BITS-1:0]              alu_out_s4,
   input  logic [BITS-1:0]              r2_data_s4,
   input  logic [BYTE_EN_W-1:0]         byte_en_s4,
   input  logic                         halt_s4,
   input  logic [BITS-1:0]              dmem_rdata,
   output logic [BITS-1:0]              dmem_addr,
   output logic [BITS-1:0]              dmem_wdata,
   output logic [BYTE_EN_W-1:0]         dmem_byte_en,
   output logic                         dmem_rw_,
   output logic                         rw_s5,
   output logic [$clog2(REG_WORDS)-1:0] waddr_s5,
   output logic [BITS-1:0]              wdata_s5,
   output logic [BYTE_EN_W-1:0]         byte_en_s5,
   output logic                         halt_s5,
   output logic                         link_valid,
   output logic [BITS-1:0]              link_addr
);

   localparam int AW = $clog2(REG_WORDS);

   logic                 kill;
   logic                 hit;
   logic                 sc_ok;
   logic [BITS-1:0]      wb_data;

   logic                 rw_s5_reg;
   logic [AW-1:0]        waddr_s5_reg;
   logic [BITS-1:0]      wdata_s5_reg;
   logic [BYTE_EN_W-1:0] byte_en_s5_reg;
   logic                 halt_s5_reg;

   assign kill         = stall | flush;
   assign dmem_addr    = alu_out_s4;
   assign dmem_wdata   = r2_data_s4;
   assign dmem_byte_en = byte_en_s4;

   // SC stores only when the reservation still matches; strobe held off during reset.
   assign dmem_rw_ = ~rst_ | kill | (check_link_s4 ? ~hit : mem_rw_s4);

   llsc_link #(
      .BITS(BITS)
   ) u_link (
      .clk        (clk),
      .rst_       (rst_),
      .kill       (kill),
      .load_link_ (load_link_s4_),
      .check_link (check_link_s4),
`ifdef LINK_SNOOP_EN
      .store_     (mem_rw_s4),
`endif
      .addr       (alu_out_s4),
      .link_valid (link_valid),
      .link_addr  (link_addr),
      .hit        (hit),
      .sc_ok      (sc_ok)
   );

   always_comb begin
      wb_data = alu_out_s4;
      case (wb_select(sel_mem_s4, atomic_s4))
         WB_MEM:  wb_data = dmem_rdata;
         WB_SC:   wb_data = {{(BITS-1){1'b0}}, sc_ok};
         default: wb_data = alu_out_s4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         rw_s5_reg      <= 1'b1;
         waddr_s5_reg   <= '0;
         wdata_s5_reg   <= '0;
         byte_en_s5_reg <= '0;
         halt_s5_reg    <= 1'b0;
      end else begin
         if (flush) begin
            rw_s5_reg      <= 1'b1;
            byte_en_s5_reg <= '0;
         end else if (!stall) begin
            rw_s5_reg      <= rw_s4;
            waddr_s5_reg   <= waddr_s4;
            wdata_s5_reg   <= wb_data;
            byte_en_s5_reg <= byte_en_s4;
         end
         if (halt_s4 && !kill)
            halt_s5_reg <= 1'b1;
      end
   end

   assign rw_s5      = rw_s5_reg;
   assign waddr_s5   = waddr_s5_reg;
   assign wdata_s5   = wdata_s5_reg;
   assign byte_en_s5 = byte_en_s5_reg;
   assign halt_s5    = halt_s5_reg;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the pipelined CPU.
- Consumes the EX/MEM register outputs (*_s4) and drives the data memory port.
- Owns the load-link/store-conditional link register and the SC success flag.
- Registers write-back controls and data (*_s5) for the regfile.

Parameters:
BITS, 32, datapath width
REG_WORDS, 32, register file depth; waddr width is $clog2(REG_WORDS)

Ports:
clk  input  1  clock
rst_  input  1  reset, asynchronous, active-low
stall  input  1  hold stage; no memory write, no link update, s5 holds
flush  input  1  squash s4 instruction; s5 becomes bubble
sel_mem_s4  input  1  write-back selects memory read data
atomic_s4  input  1  SC: write-back value is success flag
check_link_s4  input  1  instruction is SC
load_link_s4_  input  1  active-low; instruction is LL
mem_rw_s4  input  1  active-low store request
rw_s4  input  1  active-low regfile write
waddr_s4  input  $clog2(REG_WORDS)  destination register
alu_out_s4  input  BITS  effective address or ALU result
r2_data_s4  input  BITS  store data
byte_en_s4  input  4  byte enables
halt_s4  input  1  halt instruction
dmem_rdata  input  BITS  data memory read data, combinational on dmem_addr
dmem_addr  output  BITS  = alu_out_s4
dmem_wdata  output  BITS  = r2_data_s4
dmem_byte_en  output  4  = byte_en_s4
dmem_rw_  output  1  active-low write strobe
rw_s5  output  1  registered regfile write, active-low
waddr_s5  output  $clog2(REG_WORDS)  registered destination
wdata_s5  output  BITS  registered write-back data
byte_en_s5  output  4  registered byte enables
halt_s5  output  1  sticky halt
link_valid  output  1  link register holds a live reservation
link_addr  output  BITS  reserved address

Behaviour:
- Reset: rw_s5=1, waddr_s5=0, wdata_s5=0, byte_en_s5=0, halt_s5=0, link_valid=0, link_addr=0.
- Combinational outputs: dmem_addr, dmem_wdata and dmem_byte_en pass through with zero latency.
- Define kill = stall | flush and hit = link_valid & (alu_out_s4 == link_addr).
- Store strobe:
  - SC: dmem_rw_ = kill | ~hit.
  - Otherwise: dmem_rw_ = kill | mem_rw_s4.
- Link state machine, states UNLINKED/LINKED (link_valid mirrors state). Each posedge with kill=0, first match wins:
  - LL (load_link_s4_=0): link_addr<=alu_out_s4; go LINKED. This also applies when already LINKED (re-link).
  - SC: go UNLINKED whatever the outcome.
  - Otherwise: hold.
- kill=1: link state holds.
- SC result: sc_ok = hit, evaluated in the same cycle as the store.
- Write-back mux, priority order:
  - sel_mem_s4: dmem_rdata
  - atomic_s4: {BITS-1 zeros, sc_ok}
  - otherwise: alu_out_s4
- MEM/WB register, one cycle latency:
  - flush=1: rw_s5<=1, byte_en_s5<=0; waddr_s5 and wdata_s5 don't-care.
  - Else stall=1: all s5 registers hold.
  - Else: capture rw_s4, waddr_s4, selected data, byte_en_s4.
- Flush and stall together: flush wins for s5 (bubble); no write, no link change.
- halt_s5 <= halt_s5 | (halt_s4 & ~kill); stays 1 until reset.
- Reset asserted mid-operation: all state clears immediately (asynchronous); dmem_rw_ is driven 1 while rst_=0.

Optional Feature:
LINK_SNOOP_EN
- Defined: in LINKED, a committed non-SC store (kill=0, mem_rw_s4=0) with alu_out_s4==link_addr goes UNLINKED.
- LL wins over a same-cycle snoop (not reachable in a single-issue pipe).
- Undefined: only SC or a new LL changes the link state.

Decomposition:
- Shared package cpu_pkg: link_state_t enum {UNLINKED, LINKED}, BYTE_EN_W=4, and the write-back select encoding.
- One sub-module, llsc_link: owns the link state machine and emits hit/sc_ok.
- Data mux and MEM/WB register stay in mem_wb_stage.

Test Plan:
- LL at 0x100, then SC at 0x100 two cycles later with r2=0xDEAD -> dmem_rw_=0 that cycle; wdata_s5=1 next cycle; link_valid=0 after.
- LL at 0x100, SC at 0x104 -> dmem_rw_=1; wdata_s5=0; link_valid=0.
- LL at 0x100, plain SW to 0x100, then SC at 0x100:
  - LINK_SNOOP_EN defined -> SC fails (wdata_s5=0).
  - LINK_SNOOP_EN undefined -> SC succeeds (wdata_s5=1).
- SW with stall=1 for 3 cycles -> dmem_rw_=1 throughout; s5 values unchanged; stall drops -> single write; s5 updates one cycle later.
- LL with flush=1 -> link_valid stays 0; rw_s5=1 next cycle. Flush and stall together -> bubble, no write.
- halt_s4=1 pulse -> halt_s5=1 next cycle and stays 1; rst_ low mid-run -> halt_s5=0, link_valid=0, rw_s5=1 immediately, no clock required.
